uart_tx_fifo_arbiter: RTL and testbench

Shares the write port of the debug unit's UART TX FIFO between N frame-producing requesters, such as the register-dump and memory-dump engines. It grants one requester at a time, round-robin, and holds the grant for a whole frame so bytes from different requesters never interleave in the FIFO. It sits between the requesters and the TX FIFO's wr/w_data/full signals. An idle-owner timeout releases a stuck grant.

---
 rtl/uart_tx_fifo_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_fifo_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_arbiter.sv
// uart_tx_fifo_arbiter: round-robin, frame-locked arbiter sharing the UART TX FIFO write port.
// A grant is held from the first byte of a frame to its last byte; an owner that goes quiet
// for TIMEOUT consecutive cycles mid-frame loses the grant and abort pulses once.
module uart_tx_fifo_arbiter #(
  parameter int unsigned B       = 8,
  parameter int unsigned N       = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  input  logic [N*B-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  input  logic           fifo_full,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_w_data,
  output logic           busy,
  output logic           abort
);

  localparam int unsigned OW = 2;
  localparam int unsigned CW = 8;
  // Counter value on which a still-quiet owner is revoked (unused when TIMEOUT is 0).
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? CW'(0) : CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [OW-1:0] r_owner, w_owner_nxt;
  logic [OW-1:0] r_last_owner, w_last_owner_nxt;
  logic [CW-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic          r_abort, w_abort_nxt;
  logic [OW-1:0] w_pick, w_cand;
  logic          w_found;
  logic [N-1:0]  w_owner_oh;
  logic          w_own_valid;
  logic          w_own_last;
  logic [B-1:0]  w_own_data;

  assign w_owner_oh  = N'(1) << r_owner;
  assign w_own_valid = |(req_valid & w_owner_oh);
  assign w_own_last  = |(req_last & w_owner_oh);

  // Byte presented by the current owner.
  always_comb begin
    w_own_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_owner == OW'(i)) begin
        w_own_data = req_data[i*B +: B];
      end
    end
  end

  // Round-robin search: first valid requester after last_owner, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = OW'((32'(r_last_owner) + k) % N);
      if (!w_found && ((req_valid & (N'(1) << w_cand)) != '0)) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Next-state logic: arbitration, frame completion and idle-owner timeout.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_idle_cnt_nxt   = r_idle_cnt;
    w_abort_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle_cnt_nxt = '0;
        if (w_found) begin
          w_state_nxt = S_LOCKED;
          w_owner_nxt = w_pick;
        end
      end
      S_LOCKED: begin
        if (w_own_valid) begin
          // A stalled-but-valid owner is never considered idle.
          w_idle_cnt_nxt = '0;
          if (!fifo_full && w_own_last) begin
            w_state_nxt      = S_IDLE;
            w_last_owner_nxt = r_owner;
          end
        end else if ((TIMEOUT != 0) && (r_idle_cnt == TO_LAST)) begin
          w_state_nxt      = S_IDLE;
          w_last_owner_nxt = r_owner;
          w_idle_cnt_nxt   = '0;
          w_abort_nxt      = 1'b1;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; requester 0 has first priority out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(N - 1);
      r_idle_cnt   <= '0;
      r_abort      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_abort      <= w_abort_nxt;
    end
  end

  // Port-side view of the grant; writes are gated by fifo_full so none is dropped.
  always_comb begin
    grant       = '0;
    req_ready   = '0;
    fifo_wr     = 1'b0;
    fifo_w_data = '0;
    busy        = 1'b0;
    if (r_state == S_LOCKED) begin
      grant       = w_owner_oh;
      busy        = 1'b1;
      req_ready   = fifo_full ? '0 : w_owner_oh;
      fifo_wr     = w_own_valid & ~fifo_full;
      fifo_w_data = w_own_data;
    end
  end

  assign abort = r_abort;

endmodule

// File: tb/tb_uart_tx_fifo_arbiter.sv
// tb_uart_tx_fifo_arbiter: directed vector table and randomized model check of the arbiter.
module tb_uart_tx_fifo_arbiter;

  localparam int unsigned B  = 8;
  localparam int unsigned NA = 2;
  localparam int unsigned NB = 3;
  localparam int unsigned TO = 4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=2, TIMEOUT=4
  logic            rst_a;
  logic [NA-1:0]   a_valid, a_last, a_ready, a_grant;
  logic [NA*B-1:0] a_data;
  logic            a_full, a_wr, a_busy, a_abort;
  logic [B-1:0]    a_wdata;

  // Instance B: N=3, TIMEOUT=4
  logic            rst_b;
  logic [NB-1:0]   b_valid, b_last, b_ready, b_grant;
  logic [NB*B-1:0] b_data;
  logic            b_full, b_wr, b_busy, b_abort;
  logic [B-1:0]    b_wdata;

  uart_tx_fifo_arbiter #(.B(B), .N(NA), .TIMEOUT(TO)) u_a (
    .clk(clk), .reset(rst_a), .req_valid(a_valid), .req_last(a_last), .req_data(a_data),
    .req_ready(a_ready), .grant(a_grant), .fifo_full(a_full), .fifo_wr(a_wr),
    .fifo_w_data(a_wdata), .busy(a_busy), .abort(a_abort));

  uart_tx_fifo_arbiter #(.B(B), .N(NB), .TIMEOUT(TO)) u_b (
    .clk(clk), .reset(rst_b), .req_valid(b_valid), .req_last(b_last), .req_data(b_data),
    .req_ready(b_ready), .grant(b_grant), .fifo_full(b_full), .fifo_wr(b_wr),
    .fifo_w_data(b_wdata), .busy(b_busy), .abort(b_abort));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       full;
    logic [1:0] g;
    logic [1:0] rdy;
    logic       wr;
    logic [7:0] wd;
    logic       bsy;
    logic       ab;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] l, input logic [7:0] d0,
                              input logic [7:0] d1, input logic full, input logic [1:0] g,
                              input logic [1:0] rdy, input logic wr, input logic [7:0] wd,
                              input logic bsy, input logic ab);
    vec_t r;
    r.v = v; r.l = l; r.d0 = d0; r.d1 = d1; r.full = full;
    r.g = g; r.rdy = rdy; r.wr = wr; r.wd = wd; r.bsy = bsy; r.ab = ab;
    return r;
  endfunction

  function automatic vec_t idle_row(input logic [1:0] v, input logic [1:0] l,
                                    input logic [7:0] d0, input logic [7:0] d1, input logic ab);
    return mk(v, l, d0, d1, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, ab);
  endfunction

  // One cycle on instance A: drive after the edge, check mid-cycle, advance to next edge.
  task automatic apply_a(input vec_t r, input string tag, input int idx);
    a_valid = r.v; a_last = r.l; a_data = {r.d1, r.d0}; a_full = r.full;
    @(negedge clk);
    chk($sformatf("%s[%0d].grant", tag, idx), 32'(a_grant), 32'(r.g));
    chk($sformatf("%s[%0d].ready", tag, idx), 32'(a_ready), 32'(r.rdy));
    chk($sformatf("%s[%0d].wr", tag, idx), 32'(a_wr), 32'(r.wr));
    chk($sformatf("%s[%0d].data", tag, idx), 32'(a_wdata), 32'(r.wd));
    chk($sformatf("%s[%0d].busy", tag, idx), 32'(a_busy), 32'(r.bsy));
    chk($sformatf("%s[%0d].abort", tag, idx), 32'(a_abort), 32'(r.ab));
    @(posedge clk);
    #1;
  endtask

  task automatic wrap_b(input logic [2:0] v, input logic [2:0] exp_g, input int idx);
    b_valid = v; b_last = 3'b111; b_data = {8'hb2, 8'hb1, 8'hb0}; b_full = 1'b0;
    @(negedge clk);
    chk($sformatf("wrap[%0d].grant", idx), 32'(b_grant), 32'(exp_g));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  // Reference model state for instance B (owner -1 means no grant)
  int         m_owner, m_last, m_quiet, acc;
  bit         m_abort, ab_n, found;
  bit         vv[NB], ll[NB], pres[NB];
  int         sil[NB], left[NB];
  logic [7:0] rb[NB];
  logic [NB-1:0] eg;
  int         n_wr_dut, n_wr_mdl, n_ab_dut, n_ab_mdl;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = '0; a_last = '0; a_data = '0; a_full = 1'b0;
    b_valid = '0; b_last = '0; b_data = '0; b_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a.grant", 32'(a_grant), 32'h0);
    chk("rst_a.ready", 32'(a_ready), 32'h0);
    chk("rst_a.wr", 32'(a_wr), 32'h0);
    chk("rst_a.data", 32'(a_wdata), 32'h0);
    chk("rst_a.busy", 32'(a_busy), 32'h0);
    chk("rst_a.abort", 32'(a_abort), 32'h0);
    chk("rst_b.grant", 32'(b_grant), 32'h0);
    chk("rst_b.busy", 32'(b_busy), 32'h0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk);
    #1;

    // Contention with 2-byte frames, single frame, single-byte frame, quiet and stall beats
    tbl.push_back(idle_row(2'b11, 2'b00, 8'ha0, 8'hb0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 8'ha0, 8'hb0, 1'b0, 2'b01, 2'b01, 1'b1, 8'ha0, 1'b1, 1'b0));
    tbl.push_back(mk(2'b11, 2'b01, 8'ha1, 8'hb0, 1'b0, 2'b01, 2'b01, 1'b1, 8'ha1, 1'b1, 1'b0));
    tbl.push_back(idle_row(2'b11, 2'b00, 8'hc0, 8'hb0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 8'hc0, 8'hb0, 1'b0, 2'b10, 2'b10, 1'b1, 8'hb0, 1'b1, 1'b0));
    tbl.push_back(mk(2'b11, 2'b10, 8'hc0, 8'hb1, 1'b0, 2'b10, 2'b10, 1'b1, 8'hb1, 1'b1, 1'b0));
    tbl.push_back(idle_row(2'b11, 2'b00, 8'hc0, 8'hd0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 8'hc0, 8'hd0, 1'b0, 2'b01, 2'b01, 1'b1, 8'hc0, 1'b1, 1'b0));
    tbl.push_back(mk(2'b11, 2'b01, 8'hc1, 8'hd0, 1'b0, 2'b01, 2'b01, 1'b1, 8'hc1, 1'b1, 1'b0));
    tbl.push_back(idle_row(2'b10, 2'b00, 8'h00, 8'hd0, 1'b0));
    tbl.push_back(mk(2'b10, 2'b00, 8'h00, 8'hd0, 1'b0, 2'b10, 2'b10, 1'b1, 8'hd0, 1'b1, 1'b0));
    tbl.push_back(mk(2'b10, 2'b10, 8'h00, 8'hd1, 1'b0, 2'b10, 2'b10, 1'b1, 8'hd1, 1'b1, 1'b0));
    tbl.push_back(idle_row(2'b01, 2'b00, 8'h11, 8'h00, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00, 8'h11, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h11, 1'b1, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00, 8'h22, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h22, 1'b1, 1'b0));
    tbl.push_back(mk(2'b01, 2'b01, 8'h33, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h33, 1'b1, 1'b0));
    tbl.push_back(idle_row(2'b00, 2'b00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(idle_row(2'b10, 2'b10, 8'h00, 8'h5a, 1'b0));
    tbl.push_back(mk(2'b10, 2'b10, 8'h00, 8'h5a, 1'b0, 2'b10, 2'b10, 1'b1, 8'h5a, 1'b1, 1'b0));
    tbl.push_back(idle_row(2'b00, 2'b00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(idle_row(2'b01, 2'b00, 8'h77, 8'h00, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 8'h77, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 8'h77, 1'b1, 1'b0));
    tbl.push_back(mk(2'b01, 2'b01, 8'h77, 8'h00, 1'b1, 2'b01, 2'b00, 1'b0, 8'h77, 1'b1, 1'b0));
    tbl.push_back(mk(2'b01, 2'b01, 8'h77, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h77, 1'b1, 1'b0));
    tbl.push_back(idle_row(2'b00, 2'b00, 8'h00, 8'h00, 1'b0));
    foreach (tbl[i]) apply_a(tbl[i], "tbl", i);

    // Quiet for 3 cycles (one short of timeout), then 5 stalled cycles, then resume
    seq.push_back(idle_row(2'b01, 2'b00, 8'he1, 8'h00, 1'b0));
    seq.push_back(mk(2'b01, 2'b00, 8'he1, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'he1, 1'b1, 1'b0));
    repeat (3) seq.push_back(mk(2'b00, 2'b00, 8'he2, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 8'he2, 1'b1, 1'b0));
    repeat (5) seq.push_back(mk(2'b01, 2'b00, 8'he2, 8'h00, 1'b1, 2'b01, 2'b00, 1'b0, 8'he2, 1'b1, 1'b0));
    seq.push_back(mk(2'b01, 2'b00, 8'he2, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'he2, 1'b1, 1'b0));
    seq.push_back(mk(2'b01, 2'b01, 8'he3, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'he3, 1'b1, 1'b0));
    seq.push_back(idle_row(2'b00, 2'b00, 8'h00, 8'h00, 1'b0));
    foreach (seq[i]) apply_a(seq[i], "bp", i);
    seq.delete();

    // Owner drops valid after one byte; abort 4 cycles later, req1 gets the next grant
    seq.push_back(idle_row(2'b01, 2'b00, 8'hf1, 8'h00, 1'b0));
    seq.push_back(mk(2'b11, 2'b10, 8'hf1, 8'h71, 1'b0, 2'b01, 2'b01, 1'b1, 8'hf1, 1'b1, 1'b0));
    repeat (4) seq.push_back(mk(2'b10, 2'b10, 8'hf2, 8'h71, 1'b0, 2'b01, 2'b01, 1'b0, 8'hf2, 1'b1, 1'b0));
    seq.push_back(idle_row(2'b10, 2'b10, 8'hf2, 8'h71, 1'b1));
    seq.push_back(mk(2'b10, 2'b10, 8'hf2, 8'h71, 1'b0, 2'b10, 2'b10, 1'b1, 8'h71, 1'b1, 1'b0));
    seq.push_back(idle_row(2'b00, 2'b00, 8'h00, 8'h00, 1'b0));
    // Leave last_owner=0 and req1 mid-frame before the reset
    seq.push_back(idle_row(2'b01, 2'b01, 8'h31, 8'h00, 1'b0));
    seq.push_back(mk(2'b01, 2'b01, 8'h31, 8'h00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h31, 1'b1, 1'b0));
    seq.push_back(idle_row(2'b10, 2'b00, 8'h00, 8'h41, 1'b0));
    seq.push_back(mk(2'b10, 2'b00, 8'h00, 8'h41, 1'b0, 2'b10, 2'b10, 1'b1, 8'h41, 1'b1, 1'b0));
    foreach (seq[i]) apply_a(seq[i], "to", i);
    seq.delete();

    // Reset during the second byte: outputs drop without waiting for a clock edge
    a_valid = 2'b10; a_last = 2'b00; a_data = {8'h42, 8'h00}; a_full = 1'b0;
    #1;
    chk("rstmid.wr_before", 32'(a_wr), 32'h1);
    rst_a = 1'b1;
    #1;
    chk("rstmid.grant", 32'(a_grant), 32'h0);
    chk("rstmid.wr", 32'(a_wr), 32'h0);
    chk("rstmid.busy", 32'(a_busy), 32'h0);
    chk("rstmid.ready", 32'(a_ready), 32'h0);
    a_valid = 2'b00;
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    apply_a(idle_row(2'b11, 2'b00, 8'h51, 8'h42, 1'b0), "post", 0);
    apply_a(mk(2'b11, 2'b01, 8'h51, 8'h42, 1'b0, 2'b01, 2'b01, 1'b1, 8'h51, 1'b1, 1'b0), "post", 1);
    apply_a(idle_row(2'b00, 2'b00, 8'h00, 8'h00, 1'b0), "post", 2);

    // N=3 wrap: last_owner=2 out of reset, req0 and req2 both waiting
    wrap_b(3'b101, 3'b000, 0);
    wrap_b(3'b101, 3'b001, 1);
    wrap_b(3'b101, 3'b000, 2);
    wrap_b(3'b101, 3'b100, 3);
    wrap_b(3'b101, 3'b000, 4);
    wrap_b(3'b101, 3'b001, 5);
    b_valid = '0; b_last = '0;
    rst_b = 1'b1;
    #1;
    chk("rst_b2.grant", 32'(b_grant), 32'h0);
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic on instance B against the frame-level model
    m_owner = -1; m_last = NB - 1; m_quiet = 0; m_abort = 1'b0;
    n_wr_dut = 0; n_wr_mdl = 0; n_ab_dut = 0; n_ab_mdl = 0;
    for (int i = 0; i < NB; i++) begin
      pres[i] = 1'b0; sil[i] = 0; left[i] = int'($urandom_range(4, 1)); rb[i] = 8'($urandom);
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      b_valid = '0; b_last = '0;
      for (int i = 0; i < NB; i++) begin
        vv[i] = pres[i] && (sil[i] == 0);
        ll[i] = (left[i] == 1);
        if (vv[i]) b_valid = b_valid | (NB'(1) << i);
        if (ll[i]) b_last = b_last | (NB'(1) << i);
        b_data[i*B +: B] = rb[i];
      end
      b_full = ($urandom_range(3, 0) == 0);
      @(negedge clk);
      eg = (m_owner < 0) ? NB'(0) : (NB'(1) << m_owner);
      chk("rnd.grant", 32'(b_grant), 32'(eg));
      chk("rnd.ready", 32'(b_ready), b_full ? 32'h0 : 32'(eg));
      chk("rnd.wr", 32'(b_wr), ((m_owner >= 0) && vv[m_owner] && !b_full) ? 32'h1 : 32'h0);
      chk("rnd.data", 32'(b_wdata), (m_owner < 0) ? 32'h0 : 32'(rb[m_owner]));
      chk("rnd.busy", 32'(b_busy), (m_owner >= 0) ? 32'h1 : 32'h0);
      chk("rnd.abort", 32'(b_abort), 32'(m_abort));
      if (b_wr === 1'b1) n_wr_dut++;
      if (b_abort === 1'b1) n_ab_dut++;
      if (m_abort) n_ab_mdl++;

      // Model: frame-level ownership, quiet-cycle timeout
      acc = -1;
      ab_n = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= NB; k++) begin
          if (!found && vv[(m_last + k) % NB]) begin
            found = 1'b1;
            m_owner = (m_last + k) % NB;
          end
        end
        m_quiet = 0;
      end else if (vv[m_owner]) begin
        m_quiet = 0;
        if (!b_full) begin
          acc = m_owner;
          n_wr_mdl++;
          if (ll[m_owner]) begin
            m_last = m_owner;
            m_owner = -1;
          end
        end
      end else begin
        m_quiet++;
        if (m_quiet == TO) begin
          ab_n = 1'b1;
          m_last = m_owner;
          m_owner = -1;
          m_quiet = 0;
        end
      end
      m_abort = ab_n;

      // Requesters: advance on acceptance; only an owner may go quiet mid-frame
      for (int i = 0; i < NB; i++) begin
        if (acc == i) begin
          if (left[i] == 1) begin
            left[i] = int'($urandom_range(4, 1));
            pres[i] = ($urandom_range(1, 0) == 1);
          end else begin
            left[i]--;
          end
          rb[i] = 8'($urandom);
        end else if (sil[i] > 0) begin
          sil[i]--;
        end else if (!pres[i]) begin
          pres[i] = ($urandom_range(2, 0) == 0);
        end
        if ((m_owner == i) && pres[i] && (sil[i] == 0) && ($urandom_range(7, 0) == 0))
          sil[i] = int'($urandom_range(6, 1));
      end
      @(posedge clk);
      #1;
    end
    chk("rnd.write_count", 32'(n_wr_dut), 32'(n_wr_mdl));
    chk("rnd.abort_count", 32'(n_ab_dut), 32'(n_ab_mdl));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
